gcd_engine: RTL and testbench

//  Parametrised, handshaked GCD engine: merged FSM and subtract-based Euclid datapath.

---
 rtl/gcd_pkg.sv | 33 +++
 rtl/gcd_datapath.sv | 58 +++++
 rtl/gcd_engine.sv | 145 ++++++++++++++
 tb/tb_gcd_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD engine.
// Optional feature macro (see gcd_engine): GCD_ENGINE_ITER_COUNT_EN.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  // Widest operand the step helper handles; gcd_engine WIDTH must be below this.
  localparam int unsigned GcdMaxWidth = 64;

  typedef struct packed {
    logic [GcdMaxWidth-1:0] a;
    logic [GcdMaxWidth-1:0] b;
  } gcd_pair_t;

  // One Euclid subtraction step; the larger operand loses the smaller, so no underflow.
  function automatic gcd_pair_t gcd_step_f(input logic [GcdMaxWidth-1:0] a,
                                           input logic [GcdMaxWidth-1:0] b);
    gcd_pair_t r;
    r.a = a;
    r.b = b;
    if (a > b) begin
      r.a = a - b;
    end else if (b > a) begin
      r.b = b - a;
    end
    return r;
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparator and subtractor for the GCD engine.
// Strobes come from the controller in gcd_engine; load has priority over sub_a/sub_b.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             eq,
  output logic             gt,
  output logic             zero,
  output logic [WIDTH-1:0] a_or_b
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  gcd_pair_t        step;
  logic             unused_step_hi;

  // Next operand values: load new pair or apply one subtraction step.
  always_comb begin
    step = gcd_step_f(GcdMaxWidth'(a_q), GcdMaxWidth'(b_q));
    a_d  = a_q;
    b_d  = b_q;
    if (load) begin
      a_d = in_a;
      b_d = in_b;
    end else begin
      if (sub_a) a_d = step.a[WIDTH-1:0];
      if (sub_b) b_d = step.b[WIDTH-1:0];
    end
  end

  assign unused_step_hi = ^{step.a[GcdMaxWidth-1:WIDTH], step.b[GcdMaxWidth-1:WIDTH]};

  // Operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign eq     = (a_q == b_q);
  assign gt     = (a_q > b_q);
  assign zero   = (a_q == '0) || (b_q == '0);
  // Covers both terminal cases: one operand zero, or both equal.
  assign a_or_b = a_q | b_q;

endmodule

// File: rtl/gcd_engine.sv
// Handshaked subtract-based GCD engine with optional iteration bound.
// Macro GCD_ENGINE_ITER_COUNT_EN adds the out_iters port (final step count).
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_ITER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_timeout,
  output logic             busy
`ifdef GCD_ENGINE_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] out_iters
`endif
);

`ifdef GCD_ENGINE_ITER_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = (MAX_ITER != 0);
`endif

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             tmo_q, tmo_d;
  logic             load, sub_a, sub_b;
  logic             eq, gt, zero;
  logic [WIDTH-1:0] a_or_b;
  logic [WIDTH-1:0] iter_q;
  logic             iter_at_max;

  gcd_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .sub_a (sub_a),
    .sub_b (sub_b),
    .in_a  (in_a),
    .in_b  (in_b),
    .eq    (eq),
    .gt    (gt),
    .zero  (zero),
    .a_or_b(a_or_b)
  );

  // Step counter only exists when something consumes it.
  if (CountEn) begin : g_iter
    logic [WIDTH-1:0] iter_d;

    // Clear on operand load, count each subtraction.
    always_comb begin
      iter_d = iter_q;
      if (load) begin
        iter_d = '0;
      end else if (sub_a || sub_b) begin
        iter_d = iter_q + WIDTH'(1);
      end
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (rst) iter_q <= '0;
      else     iter_q <= iter_d;
    end
  end else begin : g_no_iter
    assign iter_q = '0;
  end

  assign iter_at_max = (MAX_ITER != 0) && (iter_q == WIDTH'(MAX_ITER));

  // Controller: one action per CALC cycle in fixed priority order.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    load    = 1'b0;
    sub_a   = 1'b0;
    sub_b   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (zero || eq) begin
          res_d   = a_or_b;
          tmo_d   = 1'b0;
          state_d = DONE;
        end else if (iter_at_max) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else if (gt) begin
          sub_a = 1'b1;
        end else begin
          sub_b = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          tmo_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_gcd     = res_q;
  assign out_timeout = tmo_q;

`ifdef GCD_ENGINE_ITER_COUNT_EN
  assign out_iters = out_valid ? iter_q : '0;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: three instances (W16 unbounded, W16 MAX_ITER=3, W8),
// one selected at a time; expectations go through a scoreboard queue.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid_tb;
  logic        out_ready;
  logic [15:0] in_a_tb, in_b_tb;
  logic [1:0]  sel;

  logic [2:0]  iv, ir, ov, ot, bz;
  logic [15:0] g0, g1;
  logic [7:0]  g2;
  logic [15:0] it0, it1;
  logic [7:0]  it2;

  assign iv[0] = in_valid_tb && (sel == 2'd0);
  assign iv[1] = in_valid_tb && (sel == 2'd1);
  assign iv[2] = in_valid_tb && (sel == 2'd2);

  gcd_engine #(.WIDTH(16), .MAX_ITER(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(in_a_tb), .in_b(in_b_tb),
    .out_valid(ov[0]), .out_ready(out_ready), .out_gcd(g0), .out_timeout(ot[0]), .busy(bz[0])
`ifdef GCD_ENGINE_ITER_COUNT_EN
    , .out_iters(it0)
`endif
  );

  gcd_engine #(.WIDTH(16), .MAX_ITER(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(in_a_tb), .in_b(in_b_tb),
    .out_valid(ov[1]), .out_ready(out_ready), .out_gcd(g1), .out_timeout(ot[1]), .busy(bz[1])
`ifdef GCD_ENGINE_ITER_COUNT_EN
    , .out_iters(it1)
`endif
  );

  gcd_engine #(.WIDTH(8), .MAX_ITER(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(in_a_tb[7:0]),
    .in_b(in_b_tb[7:0]), .out_valid(ov[2]), .out_ready(out_ready), .out_gcd(g2),
    .out_timeout(ot[2]), .busy(bz[2])
`ifdef GCD_ENGINE_ITER_COUNT_EN
    , .out_iters(it2)
`endif
  );

`ifndef GCD_ENGINE_ITER_COUNT_EN
  assign it0 = '0;
  assign it1 = '0;
  assign it2 = '0;
`endif

  logic        o_valid, o_ready, o_tmo, o_busy;
  logic [15:0] o_gcd, o_iters;

  always_comb begin
    o_valid = ov[sel];
    o_ready = ir[sel];
    o_tmo   = ot[sel];
    o_busy  = bz[sel];
    case (sel)
      2'd0:    begin o_gcd = g0;           o_iters = it0;           end
      2'd1:    begin o_gcd = g1;           o_iters = it1;           end
      default: begin o_gcd = {8'h00, g2};  o_iters = {8'h00, it2};  end
    endcase
  end

  typedef struct {
    logic [15:0] g;
    logic        tmo;
    int          k;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void ref_gcd(input int a, input int b, input int maxi,
                                  output int g, output bit tmo, output int k);
    k   = 0;
    tmo = 1'b0;
    g   = 0;
    for (int n = 0; n < 70000; n++) begin
      if (a == 0 || b == 0) begin g = a | b; break; end
      if (a == b) begin g = a; break; end
      if (maxi != 0 && k == maxi) begin g = 0; tmo = 1'b1; break; end
      if (a > b) a = a - b;
      else       b = b - a;
      k++;
    end
  endfunction

  // Present one operand pair to the selected DUT and record the expected result.
  task automatic drive_job(input int a, input int b, input int g, input bit tmo, input int k);
    exp_t e;
    int   n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!o_ready) begin
      errors++;
      $display("FAIL drive_ready: in_ready=%0b after %0d cycles, required 1", o_ready, n);
    end
    in_a_tb     = 16'(a);
    in_b_tb     = 16'(b);
    in_valid_tb = 1'b1;
    e.g = 16'(g);
    e.tmo = tmo;
    e.k = k;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid_tb = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, confirm it is consumed.
  task automatic collect(input string name);
    exp_t e;
    int   lat = 0;
    while (lat <= 400) begin
      @(negedge clk);
      lat++;
      if (o_valid) break;
    end
    e = sb.pop_front();
    checks++;
    if (!o_valid) begin
      errors++;
      $display("FAIL %s_valid: out_valid never rose within %0d cycles", name, lat);
    end
    checks++;
    if (lat !== 2 + e.k) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, 2 + e.k);
    end
    checks++;
    if (o_gcd !== e.g) begin
      errors++;
      $display("FAIL %s_gcd: got %0d, required %0d", name, o_gcd, e.g);
    end
    checks++;
    if (o_tmo !== e.tmo) begin
      errors++;
      $display("FAIL %s_timeout: got %0b, required %0b", name, o_tmo, e.tmo);
    end
`ifdef GCD_ENGINE_ITER_COUNT_EN
    checks++;
    if (o_iters !== 16'(e.k)) begin
      errors++;
      $display("FAIL %s_iters: got %0d, required %0d", name, o_iters, e.k);
    end
`endif
    if (out_ready) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_accept: out_valid=%0b in_ready=%0b, required 0/1", name, o_valid,
                 o_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    in_valid_tb = 1'b0;
    out_ready   = 1'b1;
    in_a_tb     = '0;
    in_b_tb     = '0;
    sel         = 2'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_tmo !== 1'b0 ||
          o_gcd !== 16'd0 || o_iters !== 16'd0) begin
        errors++;
        $display("FAIL reset_dut%0d: rdy=%0b vld=%0b busy=%0b tmo=%0b gcd=%0d it=%0d, required 1 0 0 0 0 0",
                 s, o_ready, o_valid, o_busy, o_tmo, o_gcd, o_iters);
      end
    end
    rst = 1'b0;
    sel = 2'd0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 2'd0;
    drive_job(48, 18, 6, 1'b0, 4);
    collect("basic_48_18");
  endtask

  task automatic test_zero();
    sel = 2'd0;
    drive_job(7, 0, 7, 1'b0, 0);
    collect("zero_7_0");
    drive_job(0, 9, 9, 1'b0, 0);
    collect("zero_0_9");
    drive_job(0, 0, 0, 1'b0, 0);
    collect("zero_0_0");
  endtask

  task automatic test_timeout();
    sel = 2'd1;
    drive_job(48, 18, 0, 1'b1, 3);
    collect("tmo_48_18");
    drive_job(5, 5, 5, 1'b0, 0);
    collect("tmo_next_5_5");
  endtask

  task automatic test_back_pressure();
    exp_t e;
    int   n = 0;
    sel       = 2'd0;
    out_ready = 1'b0;
    drive_job(48, 18, 6, 1'b0, 4);
    while (!o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      in_a_tb     = 16'd3;
      in_b_tb     = 16'd3;
      in_valid_tb = (i % 2) == 0;
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_gcd !== e.g || o_tmo !== 1'b0 || o_ready !== 1'b0 ||
          o_busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: vld=%0b gcd=%0d tmo=%0b rdy=%0b busy=%0b, required 1 %0d 0 0 1",
                 i, o_valid, o_gcd, o_tmo, o_ready, o_busy, e.g);
      end
    end
    in_valid_tb = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: vld=%0b rdy=%0b busy=%0b, required 0 1 0", o_valid, o_ready,
               o_busy);
    end
    drive_job(21, 14, 7, 1'b0, 2);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: busy=%0b one cycle after release, required 1", o_busy);
    end
    collect("bp_next_21_14");
  endtask

  task automatic test_reset_mid();
    sel       = 2'd0;
    out_ready = 1'b1;
    in_a_tb     = 16'd65535;
    in_b_tb     = 16'd1;
    in_valid_tb = 1'b1;
    @(posedge clk);
    #1;
    in_valid_tb = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: busy=%0b during CALC, required 1", o_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_gcd !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_idle: rdy=%0b vld=%0b busy=%0b gcd=%0d, required 1 0 0 0", o_ready,
               o_valid, o_busy, o_gcd);
    end
    rst = 1'b0;
    @(negedge clk);
    drive_job(12, 8, 4, 1'b0, 2);
    collect("rstmid_next_12_8");
  endtask

  task automatic test_random();
    int a, b, g, k;
    bit tmo;
    sel = 2'd2;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        a = 255;
        b = 1;
      end else begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
      end
      ref_gcd(a, b, 0, g, tmo, k);
      drive_job(a, b, g, tmo, k);
      collect($sformatf("rand_%0d_%0d", a, b));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_timeout();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
